// File: rtl/ecg_rate_ctrl.sv
// ECG heart-rate controller: BPM config to phase step with slewed ramps,
// beat-boundary rate changes and a mirrored phase accumulator for beats.
module ecg_rate_ctrl #(
  parameter logic [15:0] STEP_PER_BPM = 16'd11,
  parameter logic [7:0]  BPM_MIN      = 8'd30,
  parameter logic [7:0]  BPM_MAX      = 8'd240,
  parameter logic [15:0] RAMP_INC     = 16'd64,
  parameter logic [15:0] RAMP_DIV     = 16'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        cfg_valid,
  input  logic [7:0]  cfg_bpm,
  output logic        cfg_ready,
  output logic [15:0] step,
  output logic        beat_pulse,
  output logic [15:0] beat_count,
  output logic        busy
);

  typedef enum logic [1:0] {
    STOP, RAMP, TRACK, PEND
  } state_t;

  state_t      state;
  logic [15:0] target;
  logic [15:0] acc;
  logic [15:0] div;

  logic [7:0]  bpm_c;
  logic [23:0] prod;
  logic [15:0] cfg_target;
  logic [15:0] dest;
  logic [15:0] gap;
  logic [15:0] delta;
  logic [15:0] ramp_next;
  logic [16:0] sum;
  logic        accept;

  always_comb begin
    bpm_c = cfg_bpm;
    if (cfg_bpm < BPM_MIN) bpm_c = BPM_MIN;
    if (cfg_bpm > BPM_MAX) bpm_c = BPM_MAX;
  end

  assign prod = {16'd0, bpm_c} * {8'd0, STEP_PER_BPM};
  assign cfg_target = (|prod[23:16]) ? 16'hFFFF : prod[15:0];

  assign dest = run ? target : 16'd0;
  assign gap = (dest > step) ? (dest - step) : (step - dest);
  assign delta = (gap > RAMP_INC) ? RAMP_INC : gap;
  assign ramp_next = (dest > step) ? (step + delta) : (step - delta);

  // Carry out of this sum is the phase wrap the generator also sees.
  assign sum = {1'b0, acc} + {1'b0, step};

  assign cfg_ready = (state == STOP) || (state == TRACK);
  assign busy = (state == RAMP) || (state == PEND);
  assign accept = cfg_valid && cfg_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= STOP;
      target     <= 16'd0;
      acc        <= 16'd0;
      div        <= 16'd0;
      step       <= 16'd0;
      beat_pulse <= 1'b0;
      beat_count <= 16'd0;
    end else begin
      acc        <= sum[15:0];
      beat_pulse <= sum[16];
      if (sum[16]) beat_count <= beat_count + 16'd1;
      if (accept) target <= cfg_target;
      unique case (state)
        STOP: begin
          if (run && target != 16'd0) begin
            state <= RAMP;
            div   <= 16'd0;
          end
        end
        RAMP: begin
          if (step == dest) begin
            state <= (dest == 16'd0) ? STOP : TRACK;
          end else if (div == RAMP_DIV - 16'd1) begin
            div  <= 16'd0;
            step <= ramp_next;
          end else begin
            div <= div + 16'd1;
          end
        end
        TRACK: begin
          if (!run) begin
            state <= RAMP;
            div   <= 16'd0;
          end else if (accept && cfg_target != step) begin
            state <= PEND;
          end
        end
        PEND: begin
          // Rate change waits for a beat boundary unless stopping.
          if (!run || beat_pulse) begin
            state <= RAMP;
            div   <= 16'd0;
          end
        end
        default: state <= STOP;
      endcase
    end
  end

endmodule

// File: doc/ecg_rate_ctrl.md
# ecg_rate_ctrl

Heart-rate controller that sequences the ECG phase-accumulator wave generator. Accepts beats-per-minute configuration over a valid/ready handshake and converts it to a 16-bit phase step. Slews the step toward its target so rate changes never jump, and defers mid-run rate changes to a beat boundary. It mirrors the generator's 16-bit phase accumulator to emit a beat pulse and a beat count, and drives the generator's `step` input directly.

## Interface
- `STEP_PER_BPM`, 16'd11: phase-step increment per BPM; target = bpm × STEP_PER_BPM, saturated to 16'hFFFF
- `BPM_MIN`, 8'd30: lower clamp applied to `cfg_bpm`
- `BPM_MAX`, 8'd240: upper clamp applied to `cfg_bpm`
- `RAMP_INC`, 16'd64: maximum step change per ramp update
- `RAMP_DIV`, 16'd4: clocks between ramp updates (≥1)
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high; all state cleared on the clock edge where it is sampled high
- `run`  in  1  level; 1 = generate at target rate, 0 = ramp down to stop
- `cfg_valid`  in  1  new BPM offered
- `cfg_bpm`  in  8  requested beats per minute
- `cfg_ready`  out  1  controller can accept a configuration
- `step`  out  16  phase step to the wave generator (registered)
- `beat_pulse`  out  1  one-cycle pulse per mirrored phase wrap
- `beat_count`  out  16  beats since reset, wraps 16'hFFFF→0
- `busy`  out  1  state is PEND or RAMP

## Operation
- Reset values: `step`=0, `beat_pulse`=0, `beat_count`=0, `busy`=0, mirror acc=0, target=0, state=STOP. `cfg_ready`=1 from the first cycle after reset.
- Config transfer occurs when `cfg_valid`&&`cfg_ready` at a rising edge. Clamp bpm to [BPM_MIN, BPM_MAX], multiply by STEP_PER_BPM (24-bit product), saturate to 16 bits, and latch as target. The new target is visible the next cycle.
- `cfg_ready` = 1 in STOP and TRACK; 0 in PEND and RAMP.
- Ramp destination: dest = `run` ? target : 0.
- States:
  - STOP: `step`==0. On `run`=1 and target≠0 → RAMP.
  - RAMP: every RAMP_DIV clocks, `step` moves toward dest by min(RAMP_INC, |dest−step|). Direction is re-evaluated at every update, so a `run` change reverses the ramp.
    - When `step`==dest: if dest==0 → STOP; else → TRACK.
  - TRACK: `step`==target.
    - `run`=0 → RAMP (dest 0).
    - Accepted config whose new target ≠ `step` → PEND.
    - Accepted config whose new target == `step` → remain in TRACK.
  - PEND: hold `step`. At the first `beat_pulse` → RAMP. `run`=0 → RAMP immediately.
- Ramp divider: cleared on RAMP entry. The update fires when the divider == RAMP_DIV−1, then the divider restarts.
- Mirror acc: acc <= acc + `step` every cycle (mod 2^16). This is identical to the generator's accumulator, since both reset together and see the same `step`.
- Beat detection: a carry out of acc+`step` sets `beat_pulse` the next cycle and increments `beat_count`. No carry ⇒ `beat_pulse`=0.
- Config accepted in the same cycle `run` falls in TRACK: target is latched, and `run`=0 wins → RAMP to 0.
- Reset mid-ramp or mid-PEND: returns to the reset values above; the pending target is discarded.

## Timing
- `step` changes only on ramp updates. The first update is RAMP_DIV cycles after RAMP entry.
- A full ramp takes ceil(|Δ|/RAMP_INC)×RAMP_DIV cycles.
- Ramp completion: the state flips to TRACK/STOP on the cycle after `step` reaches dest. `busy` and `cfg_ready` follow the state with no added latency.
- `beat_pulse` occurs exactly 1 cycle after the edge on which acc wraps.
- The generator's `wave_out` lags its own accumulator by one cycle. Consumers align `beat_pulse` accordingly; no compensation inside this block.

## Test plan
Test parameters: STEP_PER_BPM=256, RAMP_INC=64, RAMP_DIV=4, BPM_MIN=30, BPM_MAX=240.

- Start-up: after reset, cfg bpm=60 accepted, then `run`=1 → `step` rises by 64 every 4 cycles. It reaches 15360 after 240 updates (960 cycles), then state is TRACK, `busy`=0, `cfg_ready`=1.
- Clamp/saturate: bpm=10 → target 7680; bpm=250 → 61440. With STEP_PER_BPM=512, bpm=240 → 16'hFFFF.
- Beat boundary: with TRACK at 15360, cfg bpm=120 → PEND, `cfg_ready`=0, `step` held. RAMP starts on the first `beat_pulse` and ends at 30720.
- Beat counting: step fixed at 16384 → `beat_pulse` every 4 cycles, and `beat_count` increments once per pulse. Preload to 16'hFFFF → wraps to 0.
- Stop and reversal:
  - `run`=0 in TRACK at 15360 → ramps to 0, then STOP.
  - Re-asserting `run` mid-ramp at step 8000 → the next update is +64.
- Reset mid-RAMP: `step`, `beat_count` and `busy` are 0 the next cycle, and `cfg_ready`=1.
